// File: rtl/cpu_core.sv
// 6502-subset CPU core fetching from an external synchronous memory port.
// Read data for a request arrives on mem_rdata one cycle later, so operands are consumed from it.
module cpu_core #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        A,
  output logic [7:0]        X,
  output logic [7:0]        Y,
  output logic [7:0]        P,
  output logic [ADDR_W-1:0] PC,
  output logic              sync,
  output logic              halted,
  output logic              illegal
);

  typedef enum logic [2:0] {StFetch, StDecode, StOpLo, StOpHi, StMemRd, StHalt} state_e;
  typedef enum logic [2:0] {ClsNone, ClsImp, ClsImm, ClsBr, ClsZpLd, ClsZpSt, ClsAbs, ClsBrk} cls_e;

  localparam logic [ADDR_W-1:0] PcOne = ADDR_W'(1);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [7:0]        a_q, x_q, y_q, ir_q, op1_q;
  logic              n_q, z_q, c_q, illegal_q;

  function automatic cls_e classify(input logic [7:0] op);
    cls_e cls;
    case (op)
      8'hE8, 8'hC8, 8'hCA, 8'h88, 8'hAA, 8'h8A, 8'h18, 8'h38, 8'hEA: cls = ClsImp;
      8'hA9, 8'hA2, 8'hA0, 8'h69, 8'hC9:                             cls = ClsImm;
      8'hF0, 8'hD0, 8'hB0, 8'h90:                                    cls = ClsBr;
      8'hA5, 8'hA6, 8'hA4:                                           cls = ClsZpLd;
      8'h85, 8'h86:                                                  cls = ClsZpSt;
      8'hAD, 8'hAE, 8'hAC, 8'h8D, 8'h8E, 8'h4C:                      cls = ClsAbs;
      8'h00:                                                         cls = ClsBrk;
      default:                                                       cls = ClsNone;
    endcase
    return cls;
  endfunction

  function automatic logic [1:0] nz(input logic [7:0] v);
    return {v[7], v == 8'h00};
  endfunction

  cls_e              dec_cls, ir_cls;
  logic              is_jmp, is_abs_store, br_take, rd_c, wr_c;
  logic [ADDR_W-1:0] zp_addr, ea, br_target, addr_c;
  logic [8:0]        adc_sum;
  logic [7:0]        cmp_diff, x_inc, x_dec, y_inc, y_dec;

  assign dec_cls      = classify(mem_rdata);
  assign ir_cls       = classify(ir_q);
  assign is_jmp       = (ir_q == 8'h4C);
  assign is_abs_store = (ir_q == 8'h8D) || (ir_q == 8'h8E);
  assign zp_addr      = ADDR_W'(mem_rdata);
  assign ea           = ADDR_W'({mem_rdata, op1_q});
  assign br_target    = pc_q + {{(ADDR_W-8){mem_rdata[7]}}, mem_rdata};
  assign adc_sum      = {1'b0, a_q} + {1'b0, mem_rdata} + {8'b0, c_q};
  assign cmp_diff     = a_q - mem_rdata;
  assign x_inc        = x_q + 8'd1;
  assign x_dec        = x_q - 8'd1;
  assign y_inc        = y_q + 8'd1;
  assign y_dec        = y_q - 8'd1;

  always_comb begin
    case (ir_q)
      8'hF0:   br_take = z_q;
      8'hD0:   br_take = !z_q;
      8'hB0:   br_take = c_q;
      default: br_take = !c_q;
    endcase
  end

  // Bus requests; in OPLO/OPHI the operand byte is still on mem_rdata.
  always_comb begin
    addr_c = pc_q;
    rd_c   = 1'b0;
    wr_c   = 1'b0;
    unique case (state_q)
      StFetch:  rd_c = 1'b1;
      StDecode: rd_c = dec_cls inside {ClsImm, ClsBr, ClsZpLd, ClsZpSt, ClsAbs};
      StOpLo: begin
        if (ir_cls == ClsZpLd || ir_cls == ClsZpSt) begin
          addr_c = zp_addr;
          rd_c   = (ir_cls == ClsZpLd);
          wr_c   = (ir_cls == ClsZpSt);
        end else begin
          rd_c = (ir_cls == ClsAbs);
        end
      end
      StOpHi: begin
        if (!is_jmp) begin
          addr_c = ea;
          rd_c   = !is_abs_store;
          wr_c   = is_abs_store;
        end
      end
      default: ;
    endcase
  end

  assign mem_addr  = addr_c;
  assign mem_rd    = rd_c & rst_n;
  assign mem_wr    = wr_c & rst_n;
  assign mem_wdata = ir_q[1] ? x_q : a_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      a_q       <= 8'h00;
      x_q       <= 8'h00;
      y_q       <= 8'h00;
      ir_q      <= 8'h00;
      op1_q     <= 8'h00;
      n_q       <= 1'b0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      unique case (state_q)
        StFetch: begin
          pc_q    <= pc_q + PcOne;
          state_q <= StDecode;
        end
        StDecode: begin
          ir_q    <= mem_rdata;
          state_q <= StFetch;
          case (dec_cls)
            ClsImp: begin
              case (mem_rdata)
                8'hE8: begin x_q <= x_inc; {n_q, z_q} <= nz(x_inc); end
                8'hC8: begin y_q <= y_inc; {n_q, z_q} <= nz(y_inc); end
                8'hCA: begin x_q <= x_dec; {n_q, z_q} <= nz(x_dec); end
                8'h88: begin y_q <= y_dec; {n_q, z_q} <= nz(y_dec); end
                8'hAA: begin x_q <= a_q;   {n_q, z_q} <= nz(a_q);   end
                8'h8A: begin a_q <= x_q;   {n_q, z_q} <= nz(x_q);   end
                8'h18: c_q <= 1'b0;
                8'h38: c_q <= 1'b1;
                default: ;
              endcase
            end
            ClsBrk:  state_q <= StHalt;
            ClsNone: illegal_q <= 1'b1;
            default: begin
              pc_q    <= pc_q + PcOne;
              state_q <= StOpLo;
            end
          endcase
        end
        StOpLo: begin
          op1_q   <= mem_rdata;
          state_q <= StFetch;
          case (ir_cls)
            ClsImm: begin
              case (ir_q)
                8'h69: begin
                  {c_q, a_q} <= adc_sum;
                  {n_q, z_q} <= nz(adc_sum[7:0]);
                end
                8'hC9: begin
                  c_q <= (a_q >= mem_rdata);
                  z_q <= (a_q == mem_rdata);
                  n_q <= cmp_diff[7];
                end
                default: begin
                  // Low opcode bits select the target: 01 A, 10 X, 00 Y.
                  case (ir_q[1:0])
                    2'b01:   a_q <= mem_rdata;
                    2'b10:   x_q <= mem_rdata;
                    default: y_q <= mem_rdata;
                  endcase
                  {n_q, z_q} <= nz(mem_rdata);
                end
              endcase
            end
            ClsBr:   if (br_take) pc_q <= br_target;
            ClsZpLd: state_q <= StMemRd;
            ClsAbs: begin
              pc_q    <= pc_q + PcOne;
              state_q <= StOpHi;
            end
            default: ;
          endcase
        end
        StOpHi: begin
          if (is_jmp) begin
            pc_q    <= ea;
            state_q <= StFetch;
          end else if (is_abs_store) begin
            state_q <= StFetch;
          end else begin
            state_q <= StMemRd;
          end
        end
        StMemRd: begin
          case (ir_q[1:0])
            2'b01:   a_q <= mem_rdata;
            2'b10:   x_q <= mem_rdata;
            default: y_q <= mem_rdata;
          endcase
          {n_q, z_q} <= nz(mem_rdata);
          state_q    <= StFetch;
        end
        StHalt:  state_q <= StHalt;
        default: state_q <= StFetch;
      endcase
    end
  end

  assign A       = a_q;
  assign X       = x_q;
  assign Y       = y_q;
  assign P       = {n_q, 1'b0, 1'b1, 3'b000, z_q, c_q};
  assign PC      = pc_q;
  assign sync    = (state_q == StFetch);
  assign halted  = (state_q == StHalt);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: directed programs with literal expectations, then random memory
// images checked every cycle against an instruction-level model of the ISA.
module tb_cpu_core;
  localparam int unsigned AW     = 16;
  localparam logic [15:0] RST_PC = 16'h0200;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mem_addr, PC;
  logic        mem_rd, mem_wr, sync, halted, illegal;
  logic [7:0]  mem_wdata, mem_rdata, A, X, Y, P;

  cpu_core #(.ADDR_W(AW), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .A(A), .X(X), .Y(Y), .P(P), .PC(PC),
    .sync(sync), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Image written by the stimulus; DUT and model writes live in generation-tagged overlays.
  logic [7:0]  imem [65536];
  logic [7:0]  wmem [65536];
  int unsigned wgen [65536];
  logic [7:0]  rmem [65536];
  int unsigned rgen [65536];
  int unsigned gen = 0;

  always @(posedge clk) begin
    if (mem_wr) begin
      wmem[mem_addr] <= mem_wdata;
      wgen[mem_addr] <= gen;
    end
    if (mem_rd) mem_rdata <= (wgen[mem_addr] == gen) ? wmem[mem_addr] : imem[mem_addr];
  end

  logic [7:0] ops [29] = '{8'hE8, 8'hC8, 8'hCA, 8'h88, 8'hAA, 8'h8A, 8'h18, 8'h38, 8'hEA,
                           8'hA9, 8'hA2, 8'hA0, 8'h69, 8'hC9, 8'hF0, 8'hD0, 8'hB0, 8'h90,
                           8'hA5, 8'hA6, 8'hA4, 8'h85, 8'h86, 8'hAD, 8'hAE, 8'hAC, 8'h8D,
                           8'h8E, 8'h4C};

  logic [7:0]  m_a, m_x, m_y;
  logic        m_n, m_z, m_c, m_halt, exp_ill, first;
  logic [15:0] m_pc;
  logic [23:0] wq [$];
  int          exp_cyc, since, nsync, cyc, halt_age, wr_cycles, c0;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] rref(input logic [15:0] a);
    return (rgen[a] == gen) ? rmem[a] : imem[a];
  endfunction

  function automatic logic [7:0] mem_peek(input logic [15:0] a);
    return (wgen[a] == gen) ? wmem[a] : imem[a];
  endfunction

  task automatic wref(input logic [15:0] a, input logic [7:0] d);
    rmem[a] = d;
    rgen[a] = gen;
    wq.push_back({a, d});
  endtask

  task automatic setnz(input logic [7:0] v);
    m_n = v[7];
    m_z = (v == 8'h00);
  endtask

  task automatic load(input logic [7:0] op, input logic [7:0] v);
    if (op == 8'hA9 || op == 8'hA5 || op == 8'hAD) m_a = v;
    else if (op == 8'hA2 || op == 8'hA6 || op == 8'hAE) m_x = v;
    else m_y = v;
    setnz(v);
  endtask

  // Executes one whole instruction at m_pc; exp_cyc is its sync-to-sync length.
  task automatic model_step();
    logic [7:0]  op, b, hi, v;
    logic [8:0]  s;
    logic [15:0] ea;
    op      = rref(m_pc);
    m_pc    = m_pc + 16'd1;
    exp_ill = 1'b0;
    exp_cyc = 2;
    case (op)
      8'hE8: begin m_x = m_x + 8'd1; setnz(m_x); end
      8'hC8: begin m_y = m_y + 8'd1; setnz(m_y); end
      8'hCA: begin m_x = m_x - 8'd1; setnz(m_x); end
      8'h88: begin m_y = m_y - 8'd1; setnz(m_y); end
      8'hAA: begin m_x = m_a; setnz(m_x); end
      8'h8A: begin m_a = m_x; setnz(m_a); end
      8'h18: m_c = 1'b0;
      8'h38: m_c = 1'b1;
      8'hEA: ;
      8'h00: begin m_halt = 1'b1; halt_age = 0; end
      8'hA9, 8'hA2, 8'hA0, 8'h69, 8'hC9: begin
        b = rref(m_pc); m_pc = m_pc + 16'd1; exp_cyc = 3;
        if (op == 8'h69) begin
          s = {1'b0, m_a} + {1'b0, b} + {8'b0, m_c};
          m_a = s[7:0]; m_c = s[8]; setnz(m_a);
        end else if (op == 8'hC9) begin
          v = m_a - b; m_c = (m_a >= b); m_z = (m_a == b); m_n = v[7];
        end else begin
          load(op, b);
        end
      end
      8'hF0, 8'hD0, 8'hB0, 8'h90: begin
        b = rref(m_pc); m_pc = m_pc + 16'd1; exp_cyc = 3;
        if ((op == 8'hF0 && m_z) || (op == 8'hD0 && !m_z) ||
            (op == 8'hB0 && m_c) || (op == 8'h90 && !m_c))
          m_pc = m_pc + {{8{b[7]}}, b};
      end
      8'hA5, 8'hA6, 8'hA4: begin
        b = rref(m_pc); m_pc = m_pc + 16'd1; exp_cyc = 4;
        load(op, rref({8'h00, b}));
      end
      8'h85, 8'h86: begin
        b = rref(m_pc); m_pc = m_pc + 16'd1; exp_cyc = 3;
        wref({8'h00, b}, (op == 8'h85) ? m_a : m_x);
      end
      8'hAD, 8'hAE, 8'hAC, 8'h8D, 8'h8E, 8'h4C: begin
        b  = rref(m_pc);
        hi = rref(m_pc + 16'd1);
        m_pc = m_pc + 16'd2;
        ea = {hi, b};
        if (op == 8'h4C) begin m_pc = ea; exp_cyc = 4; end
        else if (op == 8'h8D || op == 8'h8E) begin wref(ea, (op == 8'h8D) ? m_a : m_x); exp_cyc = 4; end
        else begin load(op, rref(ea)); exp_cyc = 5; end
      end
      default: exp_ill = 1'b1;
    endcase
  endtask

  // One cycle of the compare process, sampled on the falling edge.
  task automatic tick();
    logic [23:0] w;
    @(negedge clk);
    cyc++;
    if (mem_wr) wr_cycles++;
    chk("rd_wr_exclusive", {31'b0, mem_rd & mem_wr}, 32'd0);
    if (mem_wr) begin
      chk("wr_pending", {31'b0, wq.size() > 0}, 32'd1);
      if (wq.size() > 0) begin
        w = wq.pop_front();
        chk("wr_addr", mem_addr, w[23:8]);
        chk("wr_data", mem_wdata, w[7:0]);
      end
    end
    if (m_halt) begin
      halt_age++;
      if (halt_age >= 2) begin
        chk("halted", halted, 1);
        chk("halt_pc", PC, m_pc);
        chk("halt_bus", {mem_rd, mem_wr}, 0);
      end
    end else if (sync) begin
      if (!first) chk("cycles", since, exp_cyc);
      chk("writes_done", wq.size(), 0);
      chk("A", A, m_a);
      chk("X", X, m_x);
      chk("Y", Y, m_y);
      chk("P", P, {m_n, 2'b01, 3'b000, m_z, m_c});
      chk("PC", PC, m_pc);
      chk("illegal", illegal, exp_ill);
      first = 1'b0;
      since = 1;
      nsync++;
      model_step();
    end else begin
      since++;
      chk("illegal_idle", illegal, 0);
    end
  endtask

  task automatic load_prog(input logic [95:0] bytes, input int n);
    for (int i = 0; i < 65536; i++) imem[i] = 8'hEA;
    for (int i = 0; i < n; i++) imem[16'h0200 + i] = bytes[8*(n-1-i) +: 8];
  endtask

  task automatic start();
    rst_n = 1'b0;
    #1;
    chk("rd_gated", mem_rd, 0);
    chk("wr_gated", mem_wr, 0);
    gen++;
    m_a = 0; m_x = 0; m_y = 0; m_n = 0; m_z = 0; m_c = 0;
    m_pc = RST_PC; m_halt = 0; exp_ill = 0; exp_cyc = 0;
    wq.delete();
    first = 1; since = 0; nsync = 0; halt_age = 0; wr_cycles = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_pc", PC, 16'h0200);
    chk("rst_p", P, 8'h20);
    chk("rst_sync", sync, 1);
    chk("rst_halted", halted, 0);
    chk("rst_addr", mem_addr, 16'h0200);
    chk("rst_rd", mem_rd, 1);
  endtask

  task automatic run_to(input int k);
    int budget;
    budget = 8 * k + 40;
    while (nsync < k && !m_halt && budget > 0) begin
      tick();
      budget--;
    end
    chk("progress", {31'b0, (nsync >= k) || m_halt}, 32'd1);
  endtask

  initial begin
    // LDX #FF; INX wraps to zero
    load_prog(96'hA2FFE8, 3); start();
    run_to(1); c0 = cyc;
    run_to(2); chk("ldx_ff", X, 8'hFF);
    run_to(3); chk("inx_wrap", X, 8'h00); chk("inx_p", P, 8'h22);
    chk("ldx_inx_cycles", cyc - c0, 5);

    // DEX/DEY from zero
    load_prog(96'hCA88, 2); start();
    run_to(3); chk("dex_x", X, 8'hFF); chk("dey_y", Y, 8'hFF); chk("dex_p", P, 8'hA0);

    // ADC overflow into N, then carry-in wrap
    load_prog(96'hA97F690138A9FF6900, 9); start();
    run_to(3); chk("adc_a", A, 8'h80); chk("adc_p", P, 8'hA0);
    run_to(6); chk("adc_c_a", A, 8'h00); chk("adc_c_p", P, 8'h23);

    // Absolute store then absolute load
    load_prog(96'hA9428D3412AE3412, 8); start();
    run_to(2); c0 = cyc;
    run_to(3); chk("sta_cycles", cyc - c0, 4); chk("sta_wr_cycles", wr_cycles, 1);
    chk("sta_mem", mem_peek(16'h1234), 8'h42);
    c0 = cyc;
    run_to(4); chk("ldx_abs_cycles", cyc - c0, 5); chk("ldx_abs_x", X, 8'h42);

    // Taken and not-taken branches
    load_prog(96'hA200F0FC, 4); start();
    run_to(3); chk("beq_taken_pc", PC, 16'h0200);
    load_prog(96'hA200D005, 4); start();
    run_to(3); chk("bne_not_taken_pc", PC, 16'h0204);

    // Undefined opcode, then BRK
    load_prog(96'h0200, 2); start();
    run_to(2); chk("illegal_pulse", illegal, 1); chk("illegal_pc", PC, 16'h0201);
    repeat (4) tick();
    chk("brk_halted", halted, 1); chk("brk_pc", PC, 16'h0202);
    rst_n = 1'b0;
    #1 chk("rst_clears_halt", halted, 0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 65536; i++)
        imem[i] = ($urandom_range(9, 0) < 7) ? ops[$urandom_range(28, 0)] : 8'($urandom);
      start();
      run_to(300);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
